// File: rtl/register_file_mp.sv
// Register file with one write port, two registered read ports and a sequenced bulk-clear engine.
// Optional macro REGFILE_BYPASS_EN enables write-through forwarding to the read ports.
module register_file_mp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  chip_enable,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic                  read_valid,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] clear_cnt, clear_cnt_next;
    logic [DATA_WIDTH-1:0] entry [DEPTH];
    logic                  port_open;
    logic                  wr_ok;
    logic                  wr_store;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_val_a, rd_val_b;

    // A clear request on an idle edge takes priority over any port access on that edge
    assign port_open = (state == IDLE) && !clear_req && chip_enable;
    assign wr_ok     = port_open && write_enable;
    assign wr_store  = wr_ok && !((ZERO_REG != 0) && (write_addr == '0));
    assign rd_ok     = port_open && read_en;
    assign busy      = (state == CLEAR);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            clear_cnt <= '0;
        end else begin
            state     <= state_next;
            clear_cnt <= clear_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        clear_cnt_next = clear_cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clear_cnt == LAST_ADDR) begin
                    state_next     = IDLE;
                    clear_cnt_next = '0;
                end else begin
                    clear_cnt_next = clear_cnt + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_next     = IDLE;
                clear_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (state == CLEAR) begin
            entry[clear_cnt] <= '0;
        end else if (wr_store) begin
            entry[write_addr] <= write_data;
        end
    end

    // Zero masking is applied last so a hardwired entry 0 never forwards write data
    always_comb begin
        rd_val_a = entry[read_addr_a];
        rd_val_b = entry[read_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (read_addr_a == write_addr)) begin
            rd_val_a = write_data;
        end
        if (wr_ok && (read_addr_b == write_addr)) begin
            rd_val_b = write_data;
        end
`endif
        if ((ZERO_REG != 0) && (read_addr_a == '0)) begin
            rd_val_a = '0;
        end
        if ((ZERO_REG != 0) && (read_addr_b == '0)) begin
            rd_val_b = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data_a <= '0;
            read_data_b <= '0;
            read_valid  <= 1'b0;
        end else if (rd_ok) begin
            read_data_a <= rd_val_a;
            read_data_b <= rd_val_b;
            read_valid  <= 1'b1;
        end else begin
            read_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed self-checking bench for register_file_mp: a default instance and a ZERO_REG=1 instance
// share the same stimulus; expected values are hand-computed per test step.
module tb_register_file_mp;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        chip_enable;
    logic        write_enable;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic        read_en;
    logic [2:0]  read_addr_a;
    logic [2:0]  read_addr_b;
    logic        clear_req;
    logic [15:0] rd_a, rd_b, z_rd_a, z_rd_b;
    logic        rv, bz, z_rv, z_bz;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    register_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(0)) dut (
        .clock(clock), .reset_n(reset_n), .chip_enable(chip_enable),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .read_en(read_en), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(rd_a), .read_data_b(rd_b), .read_valid(rv),
        .clear_req(clear_req), .busy(bz)
    );

    register_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1)) dut_zero (
        .clock(clock), .reset_n(reset_n), .chip_enable(chip_enable),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .read_en(read_en), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .read_data_a(z_rd_a), .read_data_b(z_rd_b), .read_valid(z_rv),
        .clear_req(clear_req), .busy(z_bz)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idleInputs;
        chip_enable  = 1'b1;
        write_enable = 1'b0;
        write_addr   = '0;
        write_data   = '0;
        read_en      = 1'b0;
        read_addr_a  = '0;
        read_addr_b  = '0;
        clear_req    = 1'b0;
    endtask

    // Presents one cycle of inputs, lets one edge pass, then returns the bus to idle
    task automatic applyStimulus(input logic ce, input logic we, input logic [2:0] wa,
                                 input logic [15:0] wd, input logic re, input logic [2:0] ra,
                                 input logic [2:0] rb, input logic cr);
        chip_enable  = ce;
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        read_en      = re;
        read_addr_a  = ra;
        read_addr_b  = rb;
        clear_req    = cr;
        tick();
        idleInputs();
    endtask

    task automatic writeReg(input logic [2:0] wa, input logic [15:0] wd);
        applyStimulus(1'b1, 1'b1, wa, wd, 1'b0, 3'd0, 3'd0, 1'b0);
    endtask

    task automatic readCheck(input string tag, input logic [2:0] ra, input logic [2:0] rb,
                             input logic [15:0] exp_a, input logic [15:0] exp_b);
        applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, ra, rb, 1'b0);
        checkOutput({tag, "_a"}, 32'(rd_a), 32'(exp_a));
        checkOutput({tag, "_b"}, 32'(rd_b), 32'(exp_b));
        checkOutput({tag, "_valid"}, 32'(rv), 32'd1);
    endtask

    initial begin
        int busy_cycles;
        logic valid_seen;
        logic [15:0] exp_fwd;

        reset_n = 1'b0;
        idleInputs();
        #1;
        checkOutput("rst_data_a", 32'(rd_a), 32'h0);
        checkOutput("rst_valid", 32'(rv), 32'h0);
        checkOutput("rst_busy", 32'(bz), 32'h0);
        repeat (2) tick();
        reset_n = 1'b1;

        // Test 1: reset mid-run wipes stored data and the read registers
        writeReg(3'd2, 16'h1111);
        readCheck("pre_rst", 3'd2, 3'd2, 16'h1111, 16'h1111);
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_data", 32'(rd_a), 32'h0);
        checkOutput("async_rst_valid", 32'(rv), 32'h0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            readCheck("post_rst", 3'(i), 3'(7 - i), 16'h0, 16'h0);
        end
        tick();
        checkOutput("valid_pulse_end", 32'(rv), 32'h0);

        // Test 2: write then read on both ports
        writeReg(3'd3, 16'hBEEF);
        readCheck("rd_beef", 3'd3, 3'd3, 16'hBEEF, 16'hBEEF);
        tick();
        checkOutput("valid_drop", 32'(rv), 32'h0);
        checkOutput("data_hold", 32'(rd_a), 32'hBEEF);

        // Test 3: same-edge write and read of one address
        writeReg(3'd5, 16'h00AA);
`ifdef REGFILE_BYPASS_EN
        exp_fwd = 16'h1234;
`else
        exp_fwd = 16'h00AA;
`endif
        applyStimulus(1'b1, 1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 3'd3, 1'b0);
        checkOutput("rw_same_a", 32'(rd_a), 32'(exp_fwd));
        checkOutput("rw_same_b", 32'(rd_b), 32'hBEEF);
        readCheck("rw_after", 3'd5, 3'd5, 16'h1234, 16'h1234);

        // Test 4: bulk clear with port traffic that must be dropped
        for (int i = 0; i < 8; i++) begin
            writeReg(3'(i), 16'h0100 + 16'(i));
        end
        readCheck("fill", 3'd1, 3'd7, 16'h0101, 16'h0107);
        applyStimulus(1'b1, 1'b1, 3'd1, 16'hDEAD, 1'b1, 3'd5, 3'd5, 1'b1);
        checkOutput("clr_start_busy", 32'(bz), 32'h1);
        checkOutput("clr_start_valid", 32'(rv), 32'h0);
        checkOutput("clr_start_hold", 32'(rd_a), 32'h0101);
        write_enable = 1'b1;
        write_addr   = 3'd2;
        write_data   = 16'hBAD0;
        read_en      = 1'b1;
        read_addr_a  = 3'd2;
        read_addr_b  = 3'd2;
        busy_cycles  = 1;
        valid_seen   = 1'b0;
        for (int k = 0; k < 20 && bz; k++) begin
            tick();
            if (bz) busy_cycles++;
            if (rv) valid_seen = 1'b1;
        end
        idleInputs();
        checkOutput("clr_busy_len", 32'(busy_cycles), 32'd8);
        checkOutput("clr_no_valid", 32'(valid_seen), 32'h0);
        checkOutput("clr_rd_hold", 32'(rd_a), 32'h0101);
        for (int i = 0; i < 8; i++) begin
            readCheck("post_clr", 3'(i), 3'(i), 16'h0, 16'h0);
        end

        // Test 5: reset during the clear sequence aborts it
        for (int i = 0; i < 8; i++) begin
            writeReg(3'(i), 16'h0200 + 16'(i));
        end
        applyStimulus(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b1);
        repeat (2) tick();
        checkOutput("mid_clr_busy", 32'(bz), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(bz), 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            readCheck("post_abort", 3'(i), 3'(i), 16'h0, 16'h0);
        end
        writeReg(3'd6, 16'h5A5A);
        readCheck("after_abort", 3'd6, 3'd4, 16'h5A5A, 16'h0);

        // Test 6: hardwired entry 0 and chip_enable gating
        writeReg(3'd0, 16'hFFFF);
        readCheck("reg0_normal", 3'd0, 3'd6, 16'hFFFF, 16'h5A5A);
        checkOutput("reg0_zero_a", 32'(z_rd_a), 32'h0);
        checkOutput("reg0_zero_b", 32'(z_rd_b), 32'h5A5A);
`ifdef REGFILE_BYPASS_EN
        exp_fwd = 16'hABCD;
`else
        exp_fwd = 16'hFFFF;
`endif
        applyStimulus(1'b1, 1'b1, 3'd0, 16'hABCD, 1'b1, 3'd0, 3'd6, 1'b0);
        checkOutput("reg0_fwd_normal", 32'(rd_a), 32'(exp_fwd));
        checkOutput("reg0_fwd_zero", 32'(z_rd_a), 32'h0);
        applyStimulus(1'b0, 1'b1, 3'd6, 16'h7777, 1'b1, 3'd6, 3'd6, 1'b0);
        checkOutput("ce_off_valid", 32'(rv), 32'h0);
        readCheck("ce_off_write", 3'd6, 3'd6, 16'h5A5A, 16'h5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule
